// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised synchronous RAM.
// The optional parity path is enabled by defining RAM_PARITY_EN.
package ram_pkg;

    typedef enum logic {
        StClear,
        StIdle
    } ram_state_e;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefAddrW = 3;

    // Widest word the parity helper accepts; narrower words are zero-extended.
    localparam int unsigned MaxParityW = 1024;

    function automatic logic even_parity(input logic [MaxParityW-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps every address with a zero write after reset or a clr pulse.
// busy is decoded from the state register; clr while sweeping is ignored.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    ram_state_e        state;
    logic [ADDR_W-1:0] clr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StClear;
            clr_ptr <= '0;
        end else begin
            unique case (state)
                StClear: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    // Last address written this cycle; pointer wraps back to 0.
                    if (&clr_ptr) begin
                        state <= StIdle;
                    end
                end
                StIdle: begin
                    if (clr) begin
                        state <= StClear;
                    end
                end
                default: state <= StClear;
            endcase
        end
    end

    assign busy     = (state == StClear);
    assign clr_we   = busy;
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised single-port RAM with registered reads, read-valid strobe and clear sweep.
// Define RAM_PARITY_EN to store an even-parity bit per word and flag mismatches on reads.
module ram_sync_param
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              clr,
    output logic [DATA_W-1:0] d_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              par_err
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [Depth];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              req;
    logic              wr_en;
    logic              rd_en;

    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A clr pulse in IDLE drops the request presented in the same cycle.
    assign req   = cs && !busy && !clr;
    assign wr_en = req && rw;
    assign rd_en = req && !rw;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[addr] <= d_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                d_out <= mem[addr];
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic mem_par [Depth];

    function automatic logic word_parity(input logic [DATA_W-1:0] w);
        logic [MaxParityW-1:0] ext;
        ext             = '0;
        ext[DATA_W-1:0] = w;
        return even_parity(ext);
    endfunction

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_par[clr_addr] <= 1'b0;
        end else if (wr_en) begin
            mem_par[addr] <= word_parity(d_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else begin
            par_err <= rd_en && (word_parity(mem[addr]) != mem_par[addr]);
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sync_param.sv
// Self-checking bench for ram_sync_param against an array-based reference model.
// Define RAM_PARITY_EN to also exercise the parity error path.
module tb_ram_sync_param;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] d_in;
    logic          clr;
    logic [DW-1:0] d_out;
    logic          rd_valid;
    logic          busy;
    logic          par_err;

    ram_sync_param #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .rw       (rw),
        .addr     (addr),
        .d_in     (d_in),
        .clr      (clr),
        .d_out    (d_out),
        .rd_valid (rd_valid),
        .busy     (busy),
        .par_err  (par_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents, remaining clear cycles, expected outputs.
    logic [DW-1:0] model_mem [DEPTH];
    int            busy_left;
    logic [DW-1:0] exp_dout;
    logic          exp_valid;

    task automatic model_reset();
        busy_left = DEPTH;
        exp_dout  = '0;
        exp_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // Apply one cycle of inputs, advance one edge, update the model, sample #1 later.
    task automatic tick(input logic c, input logic r, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic cl);
        cs = c; rw = r; addr = a; d_in = d; clr = cl;
        @(posedge clk);
        if (busy_left > 0) begin
            busy_left--;
            exp_valid = 1'b0;
        end else if (cl) begin
            busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            exp_valid = 1'b0;
        end else if (c && r) begin
            model_mem[a] = d;
            exp_valid    = 1'b0;
        end else if (c) begin
            exp_dout  = model_mem[a];
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        #1;
    endtask

    task automatic idle_until_ready();
        for (int i = 0; i < 3 * DEPTH && busy_left > 0; i++) tick(0, 0, '0, '0, 0);
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL wait_ready: busy=%b required 0", busy);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        int busy_cycles;
        cs = 0; rw = 0; addr = '0; d_in = '0; clr = 0;
        rst_n = 1'b0;
        #13;
        n_checks++;
        if (d_out !== '0 || rd_valid !== 1'b0 || busy !== 1'b1 || par_err !== 1'b0) begin
            $display("FAIL reset_values: d_out=%h rd_valid=%b busy=%b par_err=%b required 0/0/1/0",
                     d_out, rd_valid, busy, par_err);
            n_fail++;
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        model_reset();
        busy_cycles = 0;
        for (int i = 0; i < 4 * DEPTH && busy === 1'b1; i++) begin
            busy_cycles++;
            tick(0, 0, '0, '0, 0);
        end
        n_checks++;
        if (busy_cycles != DEPTH) begin
            $display("FAIL reset_sweep_len: busy cycles=%0d required %0d", busy_cycles, DEPTH);
            n_fail++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            tick(1, 0, AW'(i), '0, 0);
            n_checks++;
            if (rd_valid !== 1'b1 || d_out !== '0) begin
                $display("FAIL reset_read_%0d: d_out=%h rd_valid=%b required 0000/1",
                         i, d_out, rd_valid);
                n_fail++;
            end
        end
        tick(0, 0, '0, '0, 0);
        n_checks++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL reset_valid_drop: rd_valid=%b required 0", rd_valid);
            n_fail++;
        end
    endtask

    task automatic test_write_read();
        tick(1, 1, 3'd6, 16'hABCD, 0);
        n_checks++;
        if (rd_valid !== 1'b0 || d_out !== exp_dout) begin
            $display("FAIL write_no_valid: d_out=%h rd_valid=%b required %h/0",
                     d_out, rd_valid, exp_dout);
            n_fail++;
        end
        tick(1, 0, 3'd6, '0, 0);
        n_checks++;
        if (d_out !== 16'hABCD || rd_valid !== 1'b1) begin
            $display("FAIL write_read_6: d_out=%h rd_valid=%b required abcd/1", d_out, rd_valid);
            n_fail++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 6) continue;
            tick(1, 0, AW'(i), '0, 0);
            n_checks++;
            if (d_out !== 16'h0000) begin
                $display("FAIL other_addr_%0d: d_out=%h required 0000", i, d_out);
                n_fail++;
            end
        end
    endtask

    task automatic test_write_while_busy();
        tick(0, 0, '0, '0, 1);
        n_checks++;
        if (busy !== 1'b1) begin
            $display("FAIL clr_busy: busy=%b required 1", busy);
            n_fail++;
        end
        tick(1, 1, 3'd2, 16'h1234, 0);
        tick(1, 0, 3'd2, '0, 0);
        n_checks++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL busy_read_dropped: rd_valid=%b required 0", rd_valid);
            n_fail++;
        end
        idle_until_ready();
        tick(1, 0, 3'd2, '0, 0);
        n_checks++;
        if (d_out !== 16'h0000 || rd_valid !== 1'b1) begin
            $display("FAIL busy_write_dropped: d_out=%h rd_valid=%b required 0000/1",
                     d_out, rd_valid);
            n_fail++;
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < DEPTH; i++) tick(1, 1, AW'(i), 16'hFFFF, 0);
        tick(1, 0, 3'd7, '0, 1);
        n_checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL clr_cycle_read: rd_valid=%b busy=%b required 0/1", rd_valid, busy);
            n_fail++;
        end
        idle_until_ready();
        tick(1, 0, 3'd7, '0, 0);
        n_checks++;
        if (d_out !== 16'h0000 || rd_valid !== 1'b1) begin
            $display("FAIL clear_read_7: d_out=%h rd_valid=%b required 0000/1", d_out, rd_valid);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [3];
        vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
        for (int i = 0; i < 3; i++) tick(1, 1, AW'(i), vals[i], 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, AW'(i), '0, 0);
            n_checks++;
            if (d_out !== vals[i] || rd_valid !== 1'b1) begin
                $display("FAIL b2b_read_%0d: d_out=%h rd_valid=%b required %h/1",
                         i, d_out, rd_valid, vals[i]);
                n_fail++;
            end
        end
        tick(1, 0, 3'd1, '0, 0);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (d_out !== '0 || rd_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL midread_reset: d_out=%h rd_valid=%b busy=%b required 0/0/1",
                     d_out, rd_valid, busy);
            n_fail++;
        end
        cs = 0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        model_reset();
        tick(0, 0, '0, '0, 0);
        tick(0, 0, '0, '0, 0);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (busy !== 1'b1) begin
            $display("FAIL midclear_reset: busy=%b required 1", busy);
            n_fail++;
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        model_reset();
        idle_until_ready();
        tick(1, 0, 3'd1, '0, 0);
        n_checks++;
        if (d_out !== 16'h0000 || rd_valid !== 1'b1) begin
            $display("FAIL post_reset_read: d_out=%h rd_valid=%b required 0000/1", d_out, rd_valid);
            n_fail++;
        end
    endtask

    task automatic test_random();
        logic c, r, cl;
        for (int n = 0; n < 400; n++) begin
            c  = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 1) == 1;
            cl = ($urandom_range(0, 40) == 0);
            tick(c, r, AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), cl);
            n_checks++;
            if (d_out !== exp_dout || rd_valid !== exp_valid ||
                busy !== (busy_left > 0) || par_err !== 1'b0) begin
                $display("FAIL random_%0d: d_out=%h rd_valid=%b busy=%b par_err=%b required %h/%b/%b/0",
                         n, d_out, rd_valid, busy, par_err, exp_dout, exp_valid, busy_left > 0);
                n_fail++;
            end
        end
        idle_until_ready();
    endtask

`ifdef RAM_PARITY_EN
    task automatic test_parity();
        tick(1, 1, 3'd3, 16'h0001, 0);
        dut.mem[3] = 16'h0000;
        tick(1, 0, 3'd3, '0, 0);
        n_checks++;
        if (par_err !== 1'b1 || rd_valid !== 1'b1) begin
            $display("FAIL parity_flag: par_err=%b rd_valid=%b required 1/1", par_err, rd_valid);
            n_fail++;
        end
        tick(0, 0, '0, '0, 0);
        n_checks++;
        if (par_err !== 1'b0) begin
            $display("FAIL parity_clear: par_err=%b required 0", par_err);
            n_fail++;
        end
        tick(1, 1, 3'd3, 16'h0000, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_write_while_busy();
        test_clear();
        test_back_to_back();
`ifdef RAM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
